// File: rtl/iram_access_ctrl.sv
// iram_access_ctrl: CPU-side sequencer for the 8051 internal RAM/SFR port.
// Byte, bit (as byte read-modify-write) and exchange requests.
module iram_access_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int READ_LAT      = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [ADDRESS_WIDTH-1:0] req_wdata,
  input  logic                     req_wbit,
  input  logic                     req_indirect,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADDRESS_WIDTH-1:0] rsp_data,
  output logic                     rsp_bit,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_rd,
  output logic                     ram_wr,
  output logic [ADDRESS_WIDTH-1:0] ram_in_data,
  output logic                     ram_in_bit,
  output logic                     ram_is_bit,
  output logic                     ram_indirect,
  input  logic [ADDRESS_WIDTH-1:0] ram_out
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [2:0] OP_RD_BYTE = 3'd0;
  localparam logic [2:0] OP_WR_BYTE = 3'd1;
  localparam logic [2:0] OP_RD_BIT  = 3'd2;
  localparam logic [2:0] OP_WR_BIT  = 3'd3;
  localparam logic [2:0] OP_XCH     = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_n;

  logic [2:0]      op_q;
  logic [AW-1:0]   addr_q;
  logic [2:0]      idx_q;
  logic [AW-1:0]   wdata_q;
  logic            wbit_q;
  logic            ind_q;
  logic [AW-1:0]   rbuf;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            req_is_bit;
  logic            req_is_rsv;
  logic [AW-1:0]   bit_byte;
  logic [AW-1:0]   req_byte;
  logic            q_is_bit;
  logic            q_is_rd;
  logic            q_has_data;
  logic [AW-1:0]   merged;

  assign accept = (state == S_IDLE) && req_valid;

  // classify the incoming op
  always_comb begin
    req_is_bit = 1'b0;
    req_is_rsv = 1'b0;
    unique case (1'b1)
      (req_op == OP_RD_BIT),
      (req_op == OP_WR_BIT): req_is_bit = 1'b1;
      (req_op == OP_RD_BYTE),
      (req_op == OP_WR_BYTE),
      (req_op == OP_XCH):    req_is_bit = 1'b0;
      default:               req_is_rsv = 1'b1;
    endcase
  end

  // bit address -> byte: low space maps to 20h..2Fh, high to SFR 8-aligned
  always_comb begin
    if (req_addr[AW-1])
      bit_byte = {req_addr[AW-1:3], 3'b000};
    else
      bit_byte = AW'(8'h20) + AW'(req_addr[6:3]);
    req_byte = req_is_bit ? bit_byte : req_addr;
  end

  // classify the latched op
  always_comb begin
    q_is_bit   = (op_q == OP_RD_BIT) || (op_q == OP_WR_BIT);
    q_is_rd    = (op_q == OP_RD_BYTE) || (op_q == OP_RD_BIT);
    q_has_data = (op_q == OP_RD_BYTE) || (op_q == OP_XCH)
              || (op_q == OP_WR_BIT);
  end

  // state register
  always_ff @(posedge clock) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            req_is_rsv:              state_n = S_RESP;
            (req_op == OP_WR_BYTE):  state_n = S_WRITE;
            default:                 state_n = S_READ;
          endcase
        end
      end
      S_READ: begin
        if (cnt == '0)
          state_n = q_is_rd ? S_RESP : S_WRITE;
      end
      S_WRITE: state_n = S_RESP;
      S_RESP: begin
        if (rsp_ready)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // request capture, read-latency countdown and read buffer
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q    <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wbit_q  <= 1'b0;
      ind_q   <= 1'b0;
      rbuf    <= '0;
      cnt     <= '0;
    end else if (accept) begin
      op_q    <= req_op;
      addr_q  <= req_byte;
      idx_q   <= req_addr[2:0];
      wdata_q <= req_wdata;
      wbit_q  <= req_wbit;
      ind_q   <= req_is_bit ? 1'b0 : req_indirect;
      cnt     <= CW'(READ_LAT - 1);
    end else if (state == S_READ) begin
      if (cnt == '0)
        rbuf <= ram_out;
      else
        cnt <= cnt - CW'(1);
    end
  end

  // read buffer with the addressed bit replaced
  always_comb begin
    merged        = rbuf;
    merged[idx_q] = wbit_q;
  end

  // RAM port and response outputs
  always_comb begin
    req_ready    = (state == S_IDLE);
    rsp_valid    = (state == S_RESP);
    ram_rd       = (state == S_READ);
    ram_wr       = (state == S_WRITE);
    ram_addr     = addr_q;
    ram_indirect = ind_q;
    ram_in_bit   = 1'b0;
    ram_is_bit   = 1'b0;
    ram_in_data  = '0;
    rsp_data     = '0;
    rsp_bit      = 1'b0;
    if (state == S_WRITE)
      ram_in_data = (op_q == OP_WR_BIT) ? merged : wdata_q;
    if (state == S_RESP) begin
      if (q_has_data)
        rsp_data = rbuf;
      if (q_is_bit)
        rsp_bit = rbuf[idx_q];
    end
  end

endmodule

// File: tb/tb_iram_access_ctrl.sv
// tb_iram_access_ctrl: directed checks of iram_access_ctrl
// against a behavioural RAM/SFR model.
module tb_iram_access_ctrl;

  logic       clock;
  logic       reset;
  logic       req_valid, req_ready;
  logic [2:0] req_op;
  logic [7:0] req_addr, req_wdata;
  logic       req_wbit, req_indirect;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_bit;
  logic [7:0] ram_addr, ram_in_data, ram_out;
  logic       ram_rd, ram_wr, ram_in_bit;
  logic       ram_is_bit, ram_indirect;

  logic       req_valid3, req_ready3;
  logic [2:0] req_op3;
  logic [7:0] req_addr3;
  logic       rsp_valid3, rsp_ready3;
  logic [7:0] rsp_data3;
  logic       rsp_bit3;
  logic [7:0] ram_addr3, ram_in_data3, ram_out3;
  logic       ram_rd3, ram_wr3, ram_in_bit3;
  logic       ram_is_bit3, ram_indirect3;

  logic [7:0] md [256];
  logic [7:0] mi [256];
  logic [7:0] md3 [256];

  int n_chk, n_pass;
  int rd_tot, wr_tot, ovl_tot, rd3_tot;
  logic [7:0] last_wa, last_wd;
  logic       last_wi;

  iram_access_ctrl #(.ADDRESS_WIDTH(8), .READ_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wbit(req_wbit),
    .req_indirect(req_indirect),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_bit(rsp_bit),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_in_data(ram_in_data), .ram_in_bit(ram_in_bit),
    .ram_is_bit(ram_is_bit), .ram_indirect(ram_indirect),
    .ram_out(ram_out)
  );

  iram_access_ctrl #(.ADDRESS_WIDTH(8), .READ_LAT(3)) dut3 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_op(req_op3), .req_addr(req_addr3),
    .req_wdata(8'h00), .req_wbit(1'b0),
    .req_indirect(1'b0),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_data(rsp_data3), .rsp_bit(rsp_bit3),
    .ram_addr(ram_addr3), .ram_rd(ram_rd3), .ram_wr(ram_wr3),
    .ram_in_data(ram_in_data3), .ram_in_bit(ram_in_bit3),
    .ram_is_bit(ram_is_bit3), .ram_indirect(ram_indirect3),
    .ram_out(ram_out3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // upper indirect RAM only when indirect and addr>=80h
  assign ram_out  = (ram_indirect && ram_addr[7]) ?
                    mi[ram_addr] : md[ram_addr];
  assign ram_out3 = md3[ram_addr3];

  // RAM write port
  always @(posedge clock) begin
    if (ram_wr) begin
      if (ram_indirect && ram_addr[7])
        mi[ram_addr] <= ram_in_data;
      else
        md[ram_addr] <= ram_in_data;
    end
  end

  // strobe monitor
  always @(negedge clock) begin
    if (ram_rd) rd_tot++;
    if (ram_rd3) rd3_tot++;
    if (ram_rd && ram_wr) ovl_tot++;
    if (ram_wr) begin
      wr_tot++;
      last_wa = ram_addr;
      last_wd = ram_in_data;
      last_wi = ram_indirect;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
  endtask

  task automatic do_req(
    input string      tag,
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] wd,
    input logic       wb,
    input logic       ind,
    input int         hold,
    input int         exp_lat,
    input logic [7:0] exp_data,
    input logic       exp_bit,
    input int         exp_ra,
    input int         exp_rd,
    input int         exp_wr
  );
    int rd0, wr0, lat, bad;
    @(negedge clock);
    rd0 = rd_tot;
    wr0 = wr_tot;
    req_valid    = 1'b1;
    req_op       = op;
    req_addr     = a;
    req_wdata    = wd;
    req_wbit     = wb;
    req_indirect = ind;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clock);
    while (!rsp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".data"}, rsp_data, exp_data);
    chk({tag, ".bit"}, rsp_bit, exp_bit);
    if (exp_ra >= 0)
      chk({tag, ".addr"}, ram_addr, exp_ra);
    if (hold > 0) begin
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        if (!rsp_valid || rsp_data !== exp_data ||
            rsp_bit !== exp_bit || req_ready ||
            ram_rd || ram_wr)
          bad++;
      end
      chk({tag, ".hold"}, bad, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    @(negedge clock);
    chk({tag, ".idle"}, {req_ready, rsp_valid}, 2'b10);
    chk({tag, ".nrd"}, rd_tot - rd0, exp_rd);
    chk({tag, ".nwr"}, wr_tot - wr0, exp_wr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, r0, w0;
    n_chk = 0; n_pass = 0;
    rd_tot = 0; wr_tot = 0; ovl_tot = 0; rd3_tot = 0;
    last_wa = '0; last_wd = '0; last_wi = 1'b0;
    for (int i = 0; i < 256; i++) begin
      md[i] = 8'h00; mi[i] = 8'h00; md3[i] = 8'h00;
    end
    md[8'h45] = 8'h5A;
    md[8'h22] = 8'h00;
    md[8'hD0] = 8'h80;
    md[8'h90] = 8'h11;
    mi[8'h90] = 8'h22;
    md[8'h30] = 8'h3C;
    md3[8'h45] = 8'h5A;

    reset = 1'b0;
    req_valid = 1'b0; req_op = '0; req_addr = '0;
    req_wdata = '0; req_wbit = 1'b0; req_indirect = 1'b0;
    rsp_ready = 1'b0;
    req_valid3 = 1'b0; req_op3 = '0; req_addr3 = '0;
    rsp_ready3 = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst.hs", {req_ready, rsp_valid}, 2'b10);
    chk("rst.strb", {ram_rd, ram_wr}, 2'b00);
    chk("rst.addr", ram_addr, 8'h00);
    chk("rst.wdat", ram_in_data, 8'h00);
    chk("rst.rsp", {rsp_data, rsp_bit}, 9'h000);
    chk("rst.ind", {ram_indirect, ram_is_bit, ram_in_bit}, 3'b000);
    @(posedge clock);
    #1 reset = 1'b1;

    // tag op addr wdata wbit ind hold lat data bit addr nrd nwr
    do_req("t1.rdb", 3'd0, 8'h45, 8'h00, 1'b0, 1'b0,
           0, 2, 8'h5A, 1'b0, 8'h45, 1, 0);
    do_req("t2.wbit", 3'd3, 8'h13, 8'h00, 1'b1, 1'b0,
           0, 3, 8'h00, 1'b0, 8'h22, 1, 1);
    chk("t2.wa", last_wa, 8'h22);
    chk("t2.wd", last_wd, 8'h08);
    do_req("t2.rbit", 3'd2, 8'h13, 8'h00, 1'b0, 1'b0,
           0, 2, 8'h00, 1'b1, 8'h22, 1, 0);
    do_req("t3.wbit", 3'd3, 8'hD7, 8'h00, 1'b0, 1'b1,
           0, 3, 8'h80, 1'b1, 8'hD0, 1, 1);
    chk("t3.wi", last_wi, 1'b0);
    chk("t3.mem", md[8'hD0], 8'h00);
    do_req("t4.ind", 3'd0, 8'h90, 8'h00, 1'b0, 1'b1,
           0, 2, 8'h22, 1'b0, 8'h90, 1, 0);
    do_req("t4.sfr", 3'd0, 8'h90, 8'h00, 1'b0, 1'b0,
           0, 2, 8'h11, 1'b0, 8'h90, 1, 0);
    do_req("t5.xch", 3'd4, 8'h30, 8'hA5, 1'b0, 1'b0,
           5, 3, 8'h3C, 1'b0, 8'h30, 1, 1);
    chk("t5.mem", md[8'h30], 8'hA5);
    do_req("wrb", 3'd1, 8'h50, 8'h77, 1'b0, 1'b0,
           0, 2, 8'h00, 1'b0, 8'h50, 0, 1);
    chk("wrb.mem", md[8'h50], 8'h77);
    do_req("rsv", 3'd6, 8'h12, 8'hFF, 1'b1, 1'b0,
           0, 1, 8'h00, 1'b0, -1, 0, 0);
    chk("ovl", ovl_tot, 0);

    // reset while a WR_BIT is in READ
    @(negedge clock);
    w0 = wr_tot;
    req_valid = 1'b1; req_op = 3'd3;
    req_addr = 8'h13; req_wbit = 1'b0; req_indirect = 1'b0;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    chk("t6.inrd", ram_rd, 1'b1);
    reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("t6.after", {req_ready, rsp_valid, ram_rd}, 3'b100);
    repeat (4) @(negedge clock);
    chk("t6.nwr", wr_tot - w0, 0);
    chk("t6.rv", rsp_valid, 1'b0);
    chk("t6.mem", md[8'h22], 8'h08);

    // READ_LAT=3 instance
    @(negedge clock);
    r0 = rd3_tot;
    req_valid3 = 1'b1; req_op3 = 3'd0; req_addr3 = 8'h45;
    @(posedge clock);
    #1 req_valid3 = 1'b0;
    lat = 1;
    @(negedge clock);
    while (!rsp_valid3 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    chk("l3.lat", lat, 4);
    chk("l3.data", rsp_data3, 8'h5A);
    rsp_ready3 = 1'b1;
    @(posedge clock);
    #1 rsp_ready3 = 1'b0;
    @(negedge clock);
    chk("l3.nrd", rd3_tot - r0, 3);
    chk("l3.idle", {req_ready3, rsp_valid3}, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
